decompress_row_sequencer: RTL

- Controller that streams N compressed rows from the input buffer through the run-length row decompressor and writes the expanded rows to the output buffer.
- Sits between the IO memory interface and one decompressor instance.
- Owns the decompressor's rst/enable/done handshake: clears it, fires it, and waits for done, once per row.
- Reports completion, and flags an error if the decompressor hangs.

---
 rtl/decompress_row_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/decompress_row_sequencer.sv
// rtl/decompress_row_sequencer.sv - streams compressed rows through one RLE row decompressor
//
// Purpose: for each of numRows rows, read a compressed word from srcBase+i,
// present it to the decompressor, pulse its clear, raise enable, wait for done
// (bounded by TIMEOUT cycles), then write the expanded word to dstBase+i.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, numRows, srcBase,    job request; fields latched when start is
//   dstBase                     seen in IDLE
//   memRead, memAddr, memData   source buffer read (data one cycle after read)
//   decData, decRst, decEnable, decompressor handshake
//   decDone, decOut
//   wrEn, wrAddr, wrData        destination buffer write
//   busy, finished, error       job status (error is sticky until next start)
module decompress_row_sequencer #(
  parameter int ROW_SIZE    = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int COUNT_WIDTH = 10,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] numRows,
  input  logic [ADDR_WIDTH-1:0]  srcBase,
  input  logic [ADDR_WIDTH-1:0]  dstBase,
  output logic                   memRead,
  output logic [ADDR_WIDTH-1:0]  memAddr,
  input  logic [ROW_SIZE-1:0]    memData,
  output logic [ROW_SIZE-1:0]    decData,
  output logic                   decRst,
  output logic                   decEnable,
  input  logic                   decDone,
  input  logic [ROW_SIZE-1:0]    decOut,
  output logic                   wrEn,
  output logic [ADDR_WIDTH-1:0]  wrAddr,
  output logic [ROW_SIZE-1:0]    wrData,
  output logic                   busy,
  output logic                   finished,
  output logic                   error
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_MEM, CLEAR, ARM, WAIT_DONE, WRITE, FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] num_rows_q, num_rows_d;
  logic [COUNT_WIDTH-1:0] row_idx_q, row_idx_d;
  logic [ADDR_WIDTH-1:0]  src_q, src_d;
  logic [ADDR_WIDTH-1:0]  dst_q, dst_d;
  logic [TW-1:0]          tmo_q, tmo_d;

  logic                   mem_read_q, mem_read_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [ROW_SIZE-1:0]    dec_data_q, dec_data_d;
  logic                   dec_rst_q, dec_rst_d;
  logic                   dec_en_q, dec_en_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [ROW_SIZE-1:0]    wr_data_q, wr_data_d;
  logic                   busy_q, busy_d;
  logic                   finished_q, finished_d;
  logic                   error_q, error_d;

  always_comb begin
    state_d    = state_q;
    num_rows_d = num_rows_q;
    row_idx_d  = row_idx_q;
    src_d      = src_q;
    dst_d      = dst_q;
    tmo_d      = tmo_q;
    error_d    = error_q;
    dec_data_d = dec_data_q;
    mem_addr_d = mem_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_rows_d = numRows;
          src_d      = srcBase;
          dst_d      = dstBase;
          row_idx_d  = '0;
          error_d    = 1'b0;
          state_d    = (numRows == '0) ? FINISH : FETCH;
        end
      end
      FETCH:    state_d = WAIT_MEM;
      WAIT_MEM: begin
        dec_data_d = memData;
        state_d    = CLEAR;
      end
      CLEAR:    state_d = ARM;
      ARM: begin
        tmo_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (decDone) begin
          state_d = WRITE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WRITE: begin
        if (row_idx_q == num_rows_q - 1'b1) begin
          state_d = FINISH;
        end else begin
          row_idx_d = row_idx_q + 1'b1;
          state_d   = FETCH;
        end
      end
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    mem_read_d = (state_d == FETCH);
    dec_rst_d  = (state_d == CLEAR);
    dec_en_d   = (state_d == WAIT_DONE);
    wr_en_d    = (state_d == WRITE);
    finished_d = (state_d == FINISH);
    busy_d     = (state_d != IDLE) && (state_d != FINISH);

    // Address uses the next-cycle base/index so the first row (bases still
    // on the inputs) and subsequent rows (index just incremented) both line up.
    if (state_d == FETCH) begin
      mem_addr_d = src_d + ADDR_WIDTH'(row_idx_d);
    end
    if (state_d == WRITE) begin
      wr_addr_d = dst_q + ADDR_WIDTH'(row_idx_q);
      wr_data_d = decOut;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      num_rows_q <= '0;
      row_idx_q  <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      tmo_q      <= '0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      dec_data_q <= '0;
      dec_rst_q  <= 1'b0;
      dec_en_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_rows_q <= num_rows_d;
      row_idx_q  <= row_idx_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      tmo_q      <= tmo_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      dec_data_q <= dec_data_d;
      dec_rst_q  <= dec_rst_d;
      dec_en_q   <= dec_en_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      error_q    <= error_d;
    end
  end

  assign memRead   = mem_read_q;
  assign memAddr   = mem_addr_q;
  assign decData   = dec_data_q;
  assign decRst    = dec_rst_q;
  assign decEnable = dec_en_q;
  assign wrEn      = wr_en_q;
  assign wrAddr    = wr_addr_q;
  assign wrData    = wr_data_q;
  assign busy      = busy_q;
  assign finished  = finished_q;
  assign error     = error_q;

endmodule
